// File: rtl/config_initiator.sv
`default_nettype none
// ============================================================================
// Module   : config_initiator
// Purpose  : Host-side initiator for the node configuration protocol. It packs
//            host write / read-request commands into config flits, injects
//            them into the NoC under credit flow control, and matches the
//            returning read-response flit against the single outstanding read.
// Ports    : clk_config, rst_n            clock, async active-low reset
//            cmd_*                         host command bus (valid/ready)
//            flit_out_we/wdata/credit      NoC injection port + credit return
//            flit_in_we/wdata/credit       NoC ejection port + credit return
//            rsp_valid/ready/data/timeout  read result handshake
//            busy, stray_cnt, credit_err   status
// Revision : 1.0  initial release
// ============================================================================
module config_initiator #(
   parameter int FW      = 59,
   parameter int FTW     = 3,
   parameter int ATW     = 3,
   parameter int CAW     = 15,
   parameter int CDW     = 21,
   parameter int XW      = 4,
   parameter int YW      = 4,
   parameter int CREDITS = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic           clk_config,
   input  logic           rst_n,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic           cmd_rw,
   input  logic [XW-1:0]  cmd_x,
   input  logic [YW-1:0]  cmd_y,
   input  logic [ATW-1:0] cmd_atype,
   input  logic [CAW-1:0] cmd_addr,
   input  logic [CDW-1:0] cmd_wdata,
   output logic           flit_out_we,
   output logic [FW-1:0]  flit_out_wdata,
   input  logic           flit_out_credit,
   input  logic           flit_in_we,
   input  logic [FW-1:0]  flit_in_wdata,
   output logic           flit_in_credit,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [CDW-1:0] rsp_data,
   output logic           rsp_timeout,
   output logic           busy,
   output logic [7:0]     stray_cnt,
   output logic           credit_err
);

   localparam int PADW = FW - (FTW + XW + YW + ATW + CAW + CDW);
   localparam int CW   = $clog2(CREDITS + 1);
   localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [FTW-1:0] T_WR  = FTW'(3'b100);
   localparam logic [FTW-1:0] T_RD  = FTW'(3'b101);
   localparam logic [FTW-1:0] T_RSP = FTW'(3'b110);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RSP  = 2'd2
   } state_t;

   state_t          state;
   logic [CW-1:0]   credit;
   logic [TW-1:0]   tcnt;
   logic [XW-1:0]   lat_x;
   logic [YW-1:0]   lat_y;
   logic [ATW-1:0]  lat_atype;
   logic [CAW-1:0]  lat_addr;

   // Field views of the ejected flit
   logic [FTW-1:0]  in_type;
   logic [XW-1:0]   in_x;
   logic [YW-1:0]   in_y;
   logic [ATW-1:0]  in_atype;
   logic [CAW-1:0]  in_addr;
   logic [CDW-1:0]  in_data;
   logic            unused_pad;

   assign in_type  = flit_in_wdata[FW-1 -: FTW];
   assign in_x     = flit_in_wdata[FW-FTW-1 -: XW];
   assign in_y     = flit_in_wdata[FW-FTW-XW-1 -: YW];
   assign in_atype = flit_in_wdata[FW-FTW-XW-YW-1 -: ATW];
   assign in_addr  = flit_in_wdata[FW-FTW-XW-YW-ATW-1 -: CAW];
   assign in_data  = flit_in_wdata[PADW+CDW-1 -: CDW];
   assign unused_pad = ^flit_in_wdata[PADW-1:0];

   logic            accept;
   logic            match;
   logic [FW-1:0]   new_flit;

   assign cmd_ready = (state == S_IDLE) && (credit != '0);
   assign accept    = cmd_valid && cmd_ready;

   // Only the one outstanding read can be matched; everything else is stray.
   assign match = (state == S_WAIT) && flit_in_we && (in_type == T_RSP) &&
                  (in_x == lat_x) && (in_y == lat_y) &&
                  (in_atype == lat_atype) && (in_addr == lat_addr);

   // Read requests carry a zero data field.
   assign new_flit = {cmd_rw ? T_RD : T_WR, cmd_x, cmd_y, cmd_atype, cmd_addr,
                      cmd_rw ? {CDW{1'b0}} : cmd_wdata, {PADW{1'b0}}};

   assign rsp_valid = (state == S_RSP);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk_config or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         credit         <= CW'(CREDITS);
         credit_err     <= 1'b0;
         tcnt           <= '0;
         lat_x          <= '0;
         lat_y          <= '0;
         lat_atype      <= '0;
         lat_addr       <= '0;
         flit_out_we    <= 1'b0;
         flit_out_wdata <= '0;
         flit_in_credit <= 1'b0;
         rsp_data       <= '0;
         rsp_timeout    <= 1'b0;
         stray_cnt      <= 8'd0;
      end else begin
         flit_out_we <= accept;
         if (accept) begin
            flit_out_wdata <= new_flit;
         end

         // Every ejected flit is consumed immediately, so its credit goes back
         // unconditionally one cycle later.
         flit_in_credit <= flit_in_we;

         // Simultaneous accept and credit return cancel out.
         if (accept && !flit_out_credit) begin
            credit <= credit - CW'(1);
         end else if (!accept && flit_out_credit) begin
            if (credit == CW'(CREDITS)) begin
               credit_err <= 1'b1;
            end else begin
               credit <= credit + CW'(1);
            end
         end

         if (flit_in_we && !match && (stray_cnt != 8'hFF)) begin
            stray_cnt <= stray_cnt + 8'd1;
         end

         case (state)
            S_IDLE: begin
               if (accept && cmd_rw) begin
                  lat_x     <= cmd_x;
                  lat_y     <= cmd_y;
                  lat_atype <= cmd_atype;
                  lat_addr  <= cmd_addr;
                  tcnt      <= '0;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               // Match has priority over a coincident timeout.
               if (match) begin
                  rsp_data    <= in_data;
                  rsp_timeout <= 1'b0;
                  state       <= S_RSP;
               end else if (tcnt == TW'(TIMEOUT - 1)) begin
                  rsp_data    <= '0;
                  rsp_timeout <= 1'b1;
                  state       <= S_RSP;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            S_RSP: begin
               if (rsp_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
